// File: rtl/relobi_a_dec_arbiter_pkg.sv
// Bus configuration and reliable-OBI A-channel helpers: field widths, Hsiao
// check-bit sizing and column generation, arbiter state encoding.
package obi_pkg;

  typedef struct packed {
    int unsigned DataWidth;
    int unsigned IdWidth;
    int unsigned AOptionalWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    DataWidth:      32'd32,
    IdWidth:        32'd4,
    AOptionalWidth: 32'd1
  };

endpackage

package relobi_pkg;

  localparam int unsigned RelobiCntWidth = 32'd16;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_FULL = 1'b1
  } arb_state_e;

  // Protected A-channel payload: {we, be, aid, a_optional}.
  function automatic int unsigned relobi_a_other_width(input obi_pkg::obi_cfg_t cfg);
    return 32'd1 + cfg.DataWidth / 32'd8 + cfg.IdWidth + cfg.AOptionalWidth;
  endfunction

  // SEC-DED check bits: need at least k odd-weight (>=3) columns in r bits.
  function automatic int unsigned hsiao_prot_width(input int unsigned k);
    int unsigned r;
    r = 32'd3;
    while ((32'd1 << (r - 32'd1)) < (k + r)) begin
      r = r + 32'd1;
    end
    return r;
  endfunction

  function automatic int unsigned relobi_a_other_ecc_width(input obi_pkg::obi_cfg_t cfg);
    return hsiao_prot_width(relobi_a_other_width(cfg));
  endfunction

  // Column idx of the data part of the H matrix: odd-weight vectors taken by
  // increasing weight, then increasing value.
  function automatic logic [31:0] hsiao_col(input int unsigned idx, input int unsigned r);
    logic [31:0] col;
    int unsigned n;
    col = 32'd0;
    n   = 32'd0;
    for (int unsigned w = 32'd3; w <= r; w = w + 32'd2) begin
      for (int unsigned v = 32'd0; v < (32'd1 << r); v++) begin
        if (($countones(v) == w) && (n <= idx)) begin
          col = 32'(v);
          n   = n + 32'd1;
        end else begin
          col = col;
        end
      end
    end
    return col;
  endfunction

endpackage

// File: rtl/relobi_a_dec_arbiter_hsiao.sv
// Hsiao SEC-DED decoder; codeword layout is {check bits, data}.
module hsiao_ecc_dec
  import relobi_pkg::*;
#(
  parameter int unsigned DataWidth  = 32'd32,
  parameter int unsigned ProtWidth  = hsiao_prot_width(DataWidth),
  parameter int unsigned TotalWidth = DataWidth + ProtWidth
) (
  input  logic [TotalWidth-1:0] in_i,
  output logic [DataWidth-1:0]  out_o,
  output logic [1:0]            err_o
);

  logic [ProtWidth-1:0] w_col [DataWidth];
  logic [ProtWidth-1:0] w_syn;
  logic                 w_single;

  for (genvar g = 0; g < DataWidth; g++) begin : g_col
    localparam logic [31:0] ColFull = hsiao_col(g, ProtWidth);
    assign w_col[g] = ColFull[ProtWidth-1:0];
  end

  // Syndrome: received check bits folded with the columns of every set data bit
  always_comb begin
    w_syn = in_i[TotalWidth-1:DataWidth];
    for (int i = 0; i < DataWidth; i++) begin
      w_syn = w_syn ^ (in_i[i] ? w_col[i] : '0);
    end
  end

  assign w_single = ^w_syn;

  // Flip the data bit whose column matches an odd syndrome
  always_comb begin
    out_o = in_i[DataWidth-1:0];
    for (int i = 0; i < DataWidth; i++) begin
      out_o[i] = in_i[i] ^ (w_single & (w_syn == w_col[i]));
    end
  end

  assign err_o[0] = w_single;
  assign err_o[1] = (|w_syn) & ~w_single;

endmodule

// File: rtl/relobi_a_dec_arbiter.sv
// Round-robin arbiter for reliable-OBI A-channel side fields sharing one Hsiao
// decoder, with a single output register stage and error counters.
module relobi_a_dec_arbiter
  import relobi_pkg::*;
#(
  parameter obi_pkg::obi_cfg_t Cfg           = obi_pkg::ObiDefaultConfig,
  parameter type               a_optional_t  = logic,
  parameter int unsigned       NumReq        = 32'd2,
  parameter int unsigned       OtherEccWidth = relobi_a_other_ecc_width(Cfg)
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NumReq-1:0]                             req_i,
  output logic [NumReq-1:0]                             gnt_o,
  input  logic [NumReq-1:0]                             we_i,
  input  logic [NumReq-1:0][Cfg.DataWidth/8-1:0]        be_i,
  input  logic [NumReq-1:0][Cfg.IdWidth-1:0]            aid_i,
  input  a_optional_t [NumReq-1:0]                      a_optional_i,
  input  logic [NumReq-1:0][OtherEccWidth-1:0]          other_ecc_i,
  output logic                                          req_o,
  input  logic                                          gnt_i,
  output logic                                          we_o,
  output logic [Cfg.DataWidth/8-1:0]                    be_o,
  output logic [Cfg.IdWidth-1:0]                        aid_o,
  output a_optional_t                                   a_optional_o,
  output logic [$clog2(NumReq)-1:0]                     sel_o,
  output logic                                          a_err_o,
  input  logic                                          clr_cnt_i,
  output logic [RelobiCntWidth-1:0]                     corr_cnt_o,
  output logic [RelobiCntWidth-1:0]                     uncorr_cnt_o
);

  localparam int unsigned BeWidth    = Cfg.DataWidth / 32'd8;
  localparam int unsigned IdWidth    = Cfg.IdWidth;
  localparam int unsigned OptWidth   = $bits(a_optional_t);
  localparam int unsigned OtherWidth = relobi_a_other_width(Cfg);
  localparam int unsigned SelWidth   = $clog2(NumReq);

  arb_state_e                       r_state;
  arb_state_e                       w_state_next;
  logic [SelWidth-1:0]              r_ptr;
  logic [SelWidth-1:0]              w_winner;
  logic                             w_any_req;
  logic                             w_accept;
  logic                             w_grant;
  logic [OtherWidth-1:0]            w_raw;
  logic [OtherWidth-1:0]            w_dec_out;
  logic [OtherWidth-1:0]            w_fwd;
  logic [1:0]                       w_err;
  logic                             r_we;
  logic [BeWidth-1:0]               r_be;
  logic [IdWidth-1:0]               r_aid;
  a_optional_t                      r_opt;
  logic [SelWidth-1:0]              r_sel;
  logic                             r_a_err;
  logic [RelobiCntWidth-1:0]        r_corr_cnt;
  logic [RelobiCntWidth-1:0]        r_uncorr_cnt;

  assign w_any_req = |req_i;

  // Round-robin pick: scanning offsets downwards leaves the lowest offset from r_ptr
  always_comb begin
    logic [SelWidth-1:0] cand;
    cand     = '0;
    w_winner = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      cand     = SelWidth'((int'(r_ptr) + i) % int'(NumReq));
      w_winner = req_i[cand] ? cand : w_winner;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) w_state_next = ARB_FULL;
        else           w_state_next = ARB_IDLE;
      end
      ARB_FULL: begin
        if (gnt_i) w_state_next = w_any_req ? ARB_FULL : ARB_IDLE;
        else       w_state_next = ARB_FULL;
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  // Accept/grant outputs; no grant may escape while reset is asserted
  always_comb begin
    w_accept = 1'b0;
    gnt_o    = '0;
    case (r_state)
      ARB_IDLE: w_accept = 1'b1;
      ARB_FULL: w_accept = gnt_i;
      default:  w_accept = 1'b0;
    endcase
    w_grant = w_accept & w_any_req & rst_ni;
    if (w_grant) gnt_o[w_winner] = 1'b1;
    else         gnt_o = '0;
  end

  assign w_raw = {we_i[w_winner], be_i[w_winner], aid_i[w_winner], a_optional_i[w_winner]};

  hsiao_ecc_dec #(
    .DataWidth (OtherWidth),
    .ProtWidth (OtherEccWidth)
  ) i_dec (
    .in_i  ({other_ecc_i[w_winner], w_raw}),
    .out_o (w_dec_out),
    .err_o (w_err)
  );

  // An uncorrectable word is forwarded untouched and flagged instead
  assign w_fwd = w_err[1] ? w_raw : w_dec_out;

  // Output beat register and priority pointer
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_be    <= '0;
      r_aid   <= '0;
      r_opt   <= '0;
      r_sel   <= '0;
      r_a_err <= 1'b0;
      r_ptr   <= '0;
    end else if (w_grant) begin
      r_we    <= w_fwd[OtherWidth-1];
      r_be    <= w_fwd[OptWidth+IdWidth +: BeWidth];
      r_aid   <= w_fwd[OptWidth +: IdWidth];
      r_opt   <= a_optional_t'(w_fwd[OptWidth-1:0]);
      r_sel   <= w_winner;
      r_a_err <= w_err[1];
      r_ptr   <= (w_winner == SelWidth'(NumReq - 32'd1)) ? '0 : w_winner + 1'b1;
    end
  end

  // Saturating error counters; clear dominates a same-cycle increment
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (clr_cnt_i) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      if (w_grant && w_err[0] && (r_corr_cnt != '1)) begin
        r_corr_cnt <= r_corr_cnt + RelobiCntWidth'(1);
      end
      if (w_grant && w_err[1] && (r_uncorr_cnt != '1)) begin
        r_uncorr_cnt <= r_uncorr_cnt + RelobiCntWidth'(1);
      end
    end
  end

  assign req_o        = (r_state == ARB_FULL);
  assign we_o         = r_we;
  assign be_o         = r_be;
  assign aid_o        = r_aid;
  assign a_optional_o = r_opt;
  assign sel_o        = r_sel;
  assign a_err_o      = r_a_err;
  assign corr_cnt_o   = r_corr_cnt;
  assign uncorr_cnt_o = r_uncorr_cnt;

endmodule

// File: tb/tb_relobi_a_dec_arbiter.sv
// Directed bench for relobi_a_dec_arbiter with the default configuration
// (2 requesters, 4 byte enables, 4-bit ID, 1-bit optional field, 5 ECC bits).
module tb_relobi_a_dec_arbiter;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [1:0]       req_i;
  logic [1:0]       gnt_o;
  logic [1:0]       we_i;
  logic [1:0][3:0]  be_i;
  logic [1:0][3:0]  aid_i;
  logic [1:0]       a_optional_i;
  logic [1:0][4:0]  other_ecc_i;
  logic             req_o;
  logic             gnt_i;
  logic             we_o;
  logic [3:0]       be_o;
  logic [3:0]       aid_o;
  logic             a_optional_o;
  logic             sel_o;
  logic             a_err_o;
  logic             clr_cnt_i;
  logic [15:0]      corr_cnt_o;
  logic [15:0]      uncorr_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  // Hsiao columns for payload bits {we, be[3:0], aid[3:0], opt}, LSB first
  localparam logic [4:0] COLS [10] = '{5'h07, 5'h0B, 5'h0D, 5'h0E, 5'h13,
                                       5'h15, 5'h16, 5'h19, 5'h1A, 5'h1C};

  always #5 clk_i = ~clk_i;

  relobi_a_dec_arbiter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .we_i         (we_i),
    .be_i         (be_i),
    .aid_i        (aid_i),
    .a_optional_i (a_optional_i),
    .other_ecc_i  (other_ecc_i),
    .req_o        (req_o),
    .gnt_i        (gnt_i),
    .we_o         (we_o),
    .be_o         (be_o),
    .aid_o        (aid_o),
    .a_optional_o (a_optional_o),
    .sel_o        (sel_o),
    .a_err_o      (a_err_o),
    .clr_cnt_i    (clr_cnt_i),
    .corr_cnt_o   (corr_cnt_o),
    .uncorr_cnt_o (uncorr_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a requester with a clean codeword, then flip the selected payload bits
  task automatic set_req(input int idx, input logic we, input logic [3:0] be,
                         input logic [3:0] aid, input logic opt, input logic [9:0] flip);
    logic [9:0] d;
    logic [4:0] p;
    d = {we, be, aid, opt};
    p = 5'd0;
    for (int i = 0; i < 10; i++) begin
      if (d[i]) p = p ^ COLS[i];
    end
    d = d ^ flip;
    we_i[idx]         = d[9];
    be_i[idx]         = d[8:5];
    aid_i[idx]        = d[4:1];
    a_optional_i[idx] = d[0];
    other_ecc_i[idx]  = p;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni    = 1'b0;
    req_i     = 2'b00;
    gnt_i     = 1'b0;
    clr_cnt_i = 1'b0;
    set_req(0, 1'b1, 4'hF, 4'h3, 1'b0, 10'd0);
    set_req(1, 1'b0, 4'h5, 4'h9, 1'b1, 10'd0);
    req_i = 2'b01;
    #1;
    chk("gnt_during_reset", gnt_o, 2'b00);
    tick();
    tick();
    chk("rst_req_o", req_o, 1'b0);
    chk("rst_we_o", we_o, 1'b0);
    chk("rst_be_o", be_o, 4'h0);
    chk("rst_aid_o", aid_o, 4'h0);
    chk("rst_opt_o", a_optional_o, 1'b0);
    chk("rst_sel_o", sel_o, 1'b0);
    chk("rst_a_err_o", a_err_o, 1'b0);
    chk("rst_corr_cnt", corr_cnt_o, 16'h0);
    chk("rst_uncorr_cnt", uncorr_cnt_o, 16'h0);

    // Single beat from requester 0
    rst_ni = 1'b1;
    gnt_i  = 1'b1;
    #1;
    chk("single_gnt", gnt_o, 2'b01);
    tick();
    req_i = 2'b00;
    #1;
    chk("single_req_o", req_o, 1'b1);
    chk("single_we_o", we_o, 1'b1);
    chk("single_be_o", be_o, 4'hF);
    chk("single_aid_o", aid_o, 4'h3);
    chk("single_sel_o", sel_o, 1'b0);
    chk("single_a_err", a_err_o, 1'b0);
    chk("single_no_gnt", gnt_o, 2'b00);
    tick();
    chk("single_idle", req_o, 1'b0);

    // Backpressure on a beat from requester 1
    gnt_i = 1'b0;
    req_i = 2'b10;
    #1;
    chk("bp_first_gnt", gnt_o, 2'b10);
    tick();
    set_req(1, 1'b0, 4'h5, 4'hA, 1'b1, 10'd0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_stall_gnt", gnt_o, 2'b00);
      chk("bp_stall_req_o", req_o, 1'b1);
      chk("bp_stall_sel", sel_o, 1'b1);
      chk("bp_stall_aid", aid_o, 4'h9);
      chk("bp_stall_be", be_o, 4'h5);
      chk("bp_stall_opt", a_optional_o, 1'b1);
      tick();
    end
    gnt_i = 1'b1;
    #1;
    chk("bp_release_gnt", gnt_o, 2'b10);
    tick();
    chk("bp_new_aid", aid_o, 4'hA);
    chk("bp_new_sel", sel_o, 1'b1);

    // Fairness with both requesters active
    req_i = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fair_gnt", gnt_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("fair_sel", sel_o, (k % 2 == 0) ? 1'b0 : 1'b1);
      chk("fair_aid", aid_o, (k % 2 == 0) ? 4'h3 : 4'hA);
    end
    req_i = 2'b00;
    tick();
    chk("drain_idle", req_o, 1'b0);

    // Lone requester granted on every accept
    req_i = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lone_gnt", gnt_o, 2'b01);
      tick();
    end

    // Single-bit error in be[0]
    set_req(0, 1'b1, 4'hF, 4'h3, 1'b0, 10'b00_0010_0000);
    tick();
    chk("sbe_be_o", be_o, 4'hF);
    chk("sbe_a_err", a_err_o, 1'b0);
    chk("sbe_corr_cnt", corr_cnt_o, 16'd1);
    chk("sbe_uncorr_cnt", uncorr_cnt_o, 16'd0);

    // Double-bit error in be[1:0]
    set_req(0, 1'b1, 4'hF, 4'h3, 1'b0, 10'b00_0110_0000);
    tick();
    chk("dbe_a_err", a_err_o, 1'b1);
    chk("dbe_be_o", be_o, 4'hC);
    chk("dbe_uncorr_cnt", uncorr_cnt_o, 16'd1);
    chk("dbe_corr_cnt", corr_cnt_o, 16'd1);

    // 0xFFFF+2 faulty beats in total saturate the counter
    for (int i = 0; i < 65536; i++) begin
      @(posedge clk_i);
    end
    #1;
    chk("sat_uncorr_cnt", uncorr_cnt_o, 16'hFFFF);
    chk("sat_corr_cnt", corr_cnt_o, 16'd1);
    clr_cnt_i = 1'b1;
    tick();
    clr_cnt_i = 1'b0;
    chk("clr_uncorr_cnt", uncorr_cnt_o, 16'd0);
    chk("clr_corr_cnt", corr_cnt_o, 16'd0);

    // Reset while a beat is held under backpressure
    req_i = 2'b00;
    tick();
    gnt_i = 1'b0;
    req_i = 2'b01;
    set_req(0, 1'b1, 4'hF, 4'h3, 1'b0, 10'b00_0010_0000);
    tick();
    chk("mid_full", req_o, 1'b1);
    chk("mid_corr_cnt", corr_cnt_o, 16'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt_o, 2'b00);
    tick();
    chk("mid_req_o", req_o, 1'b0);
    chk("mid_we_o", we_o, 1'b0);
    chk("mid_be_o", be_o, 4'h0);
    chk("mid_aid_o", aid_o, 4'h0);
    chk("mid_sel_o", sel_o, 1'b0);
    chk("mid_corr_cnt_zero", corr_cnt_o, 16'd0);
    rst_ni = 1'b1;
    gnt_i  = 1'b1;
    req_i  = 2'b11;
    set_req(0, 1'b1, 4'hF, 4'h3, 1'b0, 10'd0);
    #1;
    chk("ptr_after_reset", gnt_o, 2'b01);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
